fact_ctrl_fsm: RTL and testbench

Control unit for the factorial accelerator. It detects a rising edge on Go, sequences the external datapath (down-counter, product register, multiplier) through init, check and multiply loops, and reports completion or error. It drives the load/enable strobes of the data registers and the GoPulseCmb strobe consumed by the done/err capture registers.

---
 rtl/fact_ctrl_fsm.sv | 119 +++++++++++
 tb/tb_fact_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_ctrl_fsm.sv
// fact_ctrl_fsm: control unit for the factorial accelerator.
// Detects a rising edge on Go and sequences the external down-counter,
// product register and multiplier through INIT / CHECK / MULT. It reports
// completion (Done) or error (Err) as levels until the next accepted start.
// Optional build macro FACT_CTRL_ABORT_EN adds an Abort input that drops
// an in-flight run back to IDLE.
module fact_ctrl_fsm #(
  parameter int MUL_LAT = 1,
  parameter int LCW     = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Go,
  input  logic InErr,
  input  logic CntGt1,
  input  logic MulOvf,
`ifdef FACT_CTRL_ABORT_EN
  input  logic Abort,
`endif
  output logic GoPulseCmb,
  output logic LoadCnt,
  output logic SelInit,
  output logic LoadReg,
  output logic EnCnt,
  output logic Busy,
  output logic Done,
  output logic Err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    CHECK  = 3'd2,
    MULT   = 3'd3,
    DONE_S = 3'd4,
    ERR_S  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic             r_go_q;
  logic [LCW-1:0]   r_lat_cnt;
  logic             w_busy;
  logic             w_lat_zero;
  logic             w_abort;

`ifdef FACT_CTRL_ABORT_EN
  assign w_abort = Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_busy     = (r_state == INIT) || (r_state == CHECK) || (r_state == MULT);
  assign w_lat_zero = (r_lat_cnt == '0);
  // Start strobe is masked during a run, so an edge seen while busy is lost.
  assign GoPulseCmb = Go & ~r_go_q & ~w_busy;

  // State register; reset lands in IDLE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // Go history for edge detection; resets high so a Go held across reset is not an edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_go_q <= 1'b1;
    else     r_go_q <= Go;
  end

  // Multiplier dwell counter: armed in CHECK, counts down to zero in MULT.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                               r_lat_cnt <= '0;
    else if (r_state == CHECK && CntGt1)   r_lat_cnt <= LCW'(MUL_LAT - 1);
    else if (r_state == MULT && !w_lat_zero) r_lat_cnt <= r_lat_cnt - 1'b1;
  end

  // Next-state logic.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE, DONE_S, ERR_S: begin
        if (GoPulseCmb) w_nstate = InErr ? ERR_S : INIT;
      end
      INIT:  w_nstate = CHECK;
      CHECK: w_nstate = CntGt1 ? MULT : DONE_S;
      MULT: begin
        // MulOvf only matters when the multiply result is actually taken.
        if (w_lat_zero) w_nstate = MulOvf ? ERR_S : CHECK;
      end
      default: w_nstate = IDLE;
    endcase
    if (w_abort && w_busy) w_nstate = IDLE;
  end

  // Moore outputs decoded from state; register strobes are gated off on abort.
  always_comb begin
    LoadCnt = 1'b0;
    SelInit = 1'b0;
    LoadReg = 1'b0;
    EnCnt   = 1'b0;
    Busy    = w_busy;
    Done    = (r_state == DONE_S);
    Err     = (r_state == ERR_S);
    case (r_state)
      INIT: begin
        LoadCnt = 1'b1;
        SelInit = 1'b1;
        LoadReg = ~w_abort;
      end
      MULT: begin
        // Overflow cycle still loads the product; the partial result is left visible.
        LoadReg = w_lat_zero & ~w_abort;
        EnCnt   = w_lat_zero & ~w_abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl_fsm.sv
// tb_fact_ctrl_fsm: scoreboard bench for fact_ctrl_fsm.
// Two DUTs (MUL_LAT=1 and MUL_LAT=3), each with a behavioural down-counter
// and product register. Stimulus pushes the expected Done/Err event; a monitor
// pops and checks the kind, the cycle and the product when the DUT finishes.
module tb_fact_ctrl_fsm;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [1:0] go, inerr, cntgt1, mulovf;
  logic [1:0] gopulse, loadcnt, selinit, loadreg, encnt, busy, done, err;
`ifdef FACT_CTRL_ABORT_EN
  logic [1:0] abort;
`endif

  int     nval [2];
  int     cnt  [2];
  longint prod [2];
  int     nlr  [2];
  int     nec  [2];
  int     nlc  [2];
  int     cyc = 0;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int     inst;
    bit     is_err;
    int     cyc;
    longint prod;
  } exp_t;
  exp_t q[$];

  fact_ctrl_fsm #(.MUL_LAT(1), .LCW(4)) u_dut1 (
`ifdef FACT_CTRL_ABORT_EN
    .Abort(abort[0]),
`endif
    .Clk(Clk), .Rst(Rst), .Go(go[0]), .InErr(inerr[0]), .CntGt1(cntgt1[0]),
    .MulOvf(mulovf[0]), .GoPulseCmb(gopulse[0]), .LoadCnt(loadcnt[0]),
    .SelInit(selinit[0]), .LoadReg(loadreg[0]), .EnCnt(encnt[0]),
    .Busy(busy[0]), .Done(done[0]), .Err(err[0])
  );

  fact_ctrl_fsm #(.MUL_LAT(3), .LCW(4)) u_dut3 (
`ifdef FACT_CTRL_ABORT_EN
    .Abort(abort[1]),
`endif
    .Clk(Clk), .Rst(Rst), .Go(go[1]), .InErr(inerr[1]), .CntGt1(cntgt1[1]),
    .MulOvf(mulovf[1]), .GoPulseCmb(gopulse[1]), .LoadCnt(loadcnt[1]),
    .SelInit(selinit[1]), .LoadReg(loadreg[1]), .EnCnt(encnt[1]),
    .Busy(busy[1]), .Done(done[1]), .Err(err[1])
  );

  // Datapath flags derived from the behavioural models.
  always_comb begin
    inerr  = '0;
    cntgt1 = '0;
    for (int i = 0; i < 2; i++) begin
      inerr[i]  = (nval[i] > 12);
      cntgt1[i] = (cnt[i] > 1);
    end
  end

  // Down-counter, product register and strobe tallies.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (loadcnt[i])    cnt[i] <= nval[i];
      else if (encnt[i]) cnt[i] <= cnt[i] - 1;
      if (loadreg[i])    prod[i] <= selinit[i] ? 64'd1 : prod[i] * cnt[i];
      if (loadreg[i]) nlr[i] <= nlr[i] + 1;
      if (encnt[i])   nec[i] <= nec[i] + 1;
      if (loadcnt[i]) nlc[i] <= nlc[i] + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever Done or Err rises.
  initial begin
    logic [1:0] pd, pe;
    exp_t e;
    pd = '0;
    pe = '0;
    forever begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        chk("one_of_busy_done_err", (32'(busy[i]) + 32'(done[i]) + 32'(err[i])) <= 1, 1);
        if (!Rst && ((done[i] && !pd[i]) || (err[i] && !pe[i]))) begin
          if (q.size() == 0) begin
            chk("unexpected_end_inst", i, -1);
          end else begin
            e = q.pop_front();
            chk("end_inst", i, e.inst);
            chk("end_is_err", err[i], e.is_err);
            chk("end_cycle", cyc, e.cyc);
            if (!e.is_err) chk("product", prod[i], e.prod);
          end
        end
        pd[i] = done[i];
        pe[i] = err[i];
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Raise Go on instance i; optionally push the expected end event (offset from this cycle).
  task automatic start(input int i, input int n, input bit push, input bit is_err,
                       input int lat, input longint p, output int c0);
    nval[i] = n;
    go[i]   = 1'b1;
    c0      = cyc;
    #0;
    chk("start_pulse", gopulse[i], 1);
    if (push) q.push_back('{inst: i, is_err: is_err, cyc: c0 + lat, prod: p});
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) tick();
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int c0, s_lr, s_ec, s_lc;
    go = 2'b11; mulovf = '0;
    nval[0] = 0; nval[1] = 0;
`ifdef FACT_CTRL_ABORT_EN
    abort = '0;
`endif
    // Reset with Go held high.
    tick(); tick();
    chk("reset_outputs", {gopulse, loadcnt, selinit, loadreg, encnt, busy, done, err}, 0);
    Rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("go_held_no_start", {gopulse, loadcnt, selinit, loadreg, encnt, busy, done, err}, 0);
    end
    go = 2'b00;
    tick();

    // MUL_LAT=1, n=5: Done in cycle 11, 5! = 120.
    s_lr = nlr[0]; s_ec = nec[0]; s_lc = nlc[0];
    start(0, 5, 1, 0, 11, 120, c0);
    tick();
    chk("init_strobes", {loadcnt[0], selinit[0], loadreg[0], busy[0]}, 4'b1111);
    go[0] = 1'b0;
    drain();
    chk("n5_encnt_pulses", nec[0] - s_ec, 4);
    chk("n5_loadreg_pulses", nlr[0] - s_lr, 5);
    chk("n5_loadcnt_pulses", nlc[0] - s_lc, 1);

    // MUL_LAT=3, n=4: Done in cycle 15, LoadReg only in final MULT cycle.
    s_lr = nlr[1]; s_ec = nec[1];
    start(1, 4, 1, 0, 15, 24, c0);
    tick();
    go[1] = 1'b0;
    drain();
    chk("lat3_loadreg_pulses", nlr[1] - s_lr, 4);
    chk("lat3_encnt_pulses", nec[1] - s_ec, 3);

    // MUL_LAT=3, n=0: Done in cycle 3, product 1.
    tick();
    start(1, 0, 1, 0, 3, 1, c0);
    tick();
    go[1] = 1'b0;
    drain();

    // Input error n=13: Err in cycle 1, no counter load.
    tick();
    s_lc = nlc[0]; s_lr = nlr[0];
    start(0, 13, 1, 1, 1, 0, c0);
    tick();
    chk("inerr_err_cycle1", {err[0], busy[0], loadcnt[0]}, 3'b100);
    go[0] = 1'b0;
    tick(); tick();
    chk("inerr_no_loadcnt", nlc[0] - s_lc, 0);
    chk("inerr_no_loadreg", nlr[0] - s_lr, 0);
    drain();
    // Restart from ERR_S with n=1.
    start(0, 1, 1, 0, 3, 1, c0);
    tick();
    chk("err_clears_on_start", {err[0], busy[0]}, 2'b01);
    go[0] = 1'b0;
    drain();

    // n=1: Go rising while the FSM is moving into DONE_S is ignored.
    tick();
    start(0, 1, 1, 0, 3, 1, c0);
    tick();
    go[0] = 1'b0;
    tick();
    go[0] = 1'b1;
    #0;
    chk("go_in_check_masked", gopulse[0], 0);
    tick();
    chk("go_lost_after_done", gopulse[0], 0);
    drain();
    tick(); tick();
    chk("stays_done", {done[0], busy[0]}, 2'b10);
    go[0] = 1'b0;
    tick();

    // n=5, overflow on the 2nd multiply's final cycle; Go toggle mid-run ignored.
    start(0, 5, 1, 1, 6, 0, c0);
    to_cycle(c0 + 2);
    go[0] = 1'b0;
    to_cycle(c0 + 3);
    go[0] = 1'b1;
    #0;
    chk("go_midrun_masked", gopulse[0], 0);
    to_cycle(c0 + 5);
    mulovf[0] = 1'b1;
    #0;
    chk("ovf_cycle_loadreg", loadreg[0], 1);
    to_cycle(c0 + 6);
    mulovf[0] = 1'b0;
    chk("ovf_err_state", {err[0], busy[0], done[0]}, 3'b100);
    go[0] = 1'b0;
    drain();

    // Reset in the middle of a MULT dwell.
    tick();
    start(1, 4, 0, 0, 0, 0, c0);
    tick();
    go[1] = 1'b0;
    to_cycle(c0 + 4);
    chk("midrun_busy", busy[1], 1);
    #2;
    Rst = 1'b1;
    #1;
    chk("reset_midrun_outputs", {gopulse, loadcnt, selinit, loadreg, encnt, busy, done, err}, 0);
    tick();
    Rst = 1'b0;
    tick();
    chk("after_reset_idle", {busy, done, err}, 0);

`ifdef FACT_CTRL_ABORT_EN
    // Abort in the first MULT cycle returns to IDLE with strobes suppressed.
    start(0, 5, 0, 0, 0, 0, c0);
    tick();
    go[0] = 1'b0;
    to_cycle(c0 + 3);
    abort[0] = 1'b1;
    #0;
    chk("abort_strobes_off", {loadreg[0], encnt[0], busy[0]}, 3'b001);
    tick();
    abort[0] = 1'b0;
    chk("abort_to_idle", {busy[0], done[0], err[0]}, 3'b000);
    tick(); tick();
    chk("abort_stays_idle", {busy[0], done[0], err[0]}, 3'b000);
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
